check_word_serializer: RTL and testbench

//  Downstream consumer of the Example checker stage. Captures each 64-bit checkData word when check1 strobes.

---
 rtl/check_word_serializer_if.sv | 25 ++
 rtl/check_word_serializer.sv | 77 +++++++
 tb/tb_check_word_serializer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/check_word_serializer_if.sv
// check_word_serializer_if: capture-side and byte-stream signals of the check word serializer
interface check_word_serializer_if #(
  parameter int WORD_BYTES = 8,
  parameter int BYTE_W     = 8,
  parameter int CNT_W      = 8
);
  logic                         check1;
  logic                         check2;
  logic [WORD_BYTES*BYTE_W-1:0] checkData;
  logic [BYTE_W-1:0]            byteOut;
  logic                         byteValid;
  logic                         byteReady;
  logic                         byteLast;
  logic                         tagOut;
  logic                         busy;
  logic [CNT_W-1:0]             dropCount;
  modport master (
    output check1, check2, checkData, byteReady,
    input  byteOut, byteValid, byteLast, tagOut, busy, dropCount
  );
  modport slave (
    input  check1, check2, checkData, byteReady,
    output byteOut, byteValid, byteLast, tagOut, busy, dropCount
  );
endinterface

// File: rtl/check_word_serializer.sv
// check_word_serializer: captures tagged check words and streams them MSB byte first, one word pending
module check_word_serializer #(
  parameter int WORD_BYTES = 8,
  parameter int BYTE_W     = 8,
  parameter int CNT_W      = 8
) (
  input logic                    clock,
  input logic                    clear,
  check_word_serializer_if.slave bus
);
  localparam int W     = WORD_BYTES * BYTE_W;
  localparam int IDX_W = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t             state_q;
  logic [W-1:0]       data_q, pend_q, sel;
  logic               tag_q, pend_tag_q, pend_full_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   drop_q;
  logic               send, accept, last, done;
  assign send   = state_q == SEND;
  assign accept = send && bus.byteReady;
  assign last   = idx_q == IDX_W'(WORD_BYTES - 1);
  assign done   = accept && last;
  assign sel    = data_q >> ((WORD_BYTES - 1 - int'(idx_q)) * BYTE_W);
  assign bus.byteOut   = send ? sel[BYTE_W-1:0] : '0;
  assign bus.byteValid = send;
  assign bus.byteLast  = send && last;
  assign bus.tagOut    = send && tag_q;
  assign bus.busy      = send || pend_full_q;
  assign bus.dropCount = drop_q;
  // Drain of the pending slot is resolved before the new capture, so a capture
  // on the same edge as a drain always finds room.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      data_q      <= '0;
      tag_q       <= 1'b0;
      pend_q      <= '0;
      pend_tag_q  <= 1'b0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      drop_q      <= '0;
    end else if (!send) begin
      if (bus.check1) begin
        state_q <= SEND;
        data_q  <= bus.checkData;
        tag_q   <= bus.check2;
        idx_q   <= '0;
      end
    end else if (done) begin
      idx_q <= '0;
      if (pend_full_q) begin
        data_q      <= pend_q;
        tag_q       <= pend_tag_q;
        pend_full_q <= bus.check1;
        if (bus.check1) begin
          pend_q     <= bus.checkData;
          pend_tag_q <= bus.check2;
        end
      end else if (bus.check1) begin
        data_q <= bus.checkData;
        tag_q  <= bus.check2;
      end else begin
        state_q <= IDLE;
      end
    end else begin
      if (accept) idx_q <= idx_q + IDX_W'(1);
      if (bus.check1 && !pend_full_q) begin
        pend_q      <= bus.checkData;
        pend_tag_q  <= bus.check2;
        pend_full_q <= 1'b1;
      end else if (bus.check1 && drop_q != '1) begin
        drop_q <= drop_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_check_word_serializer.sv
// tb_check_word_serializer: directed checks of capture, byte streaming, pending/drop and clear
module tb_check_word_serializer;
  logic clock = 1'b0;
  logic clear = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  check_word_serializer_if bus ();
  check_word_serializer dut (.clock(clock), .clear(clear), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  function automatic logic [7:0] byte_of(input logic [63:0] w, input int i);
    logic [63:0] s;
    s = w >> (56 - 8 * i);
    return s[7:0];
  endfunction
  task automatic strobe(input logic [63:0] w, input logic t);
    bus.check1 = 1'b1;
    bus.checkData = w;
    bus.check2 = t;
    tick();
    bus.check1 = 1'b0;
  endtask
  task automatic drain(input string tag, input logic [63:0] w, input logic t);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_valid"}, 64'(bus.byteValid), 64'd1);
      chk({tag, "_byte"}, 64'(bus.byteOut), 64'(byte_of(w, i)));
      chk({tag, "_last"}, 64'(bus.byteLast), 64'(i == 7));
      chk({tag, "_tag"}, 64'(bus.tagOut), 64'(t));
      tick();
    end
  endtask
  initial begin
    logic [7:0] prev;
    int got;
    logic rdy;
    bus.check1 = 1'b0;
    bus.check2 = 1'b0;
    bus.checkData = '0;
    bus.byteReady = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(bus.byteValid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_drop", 64'(bus.dropCount), 64'd0);
    chk("rst_byte", 64'(bus.byteOut), 64'd0);
    chk("rst_last", 64'(bus.byteLast), 64'd0);
    chk("rst_tag", 64'(bus.tagOut), 64'd0);
    clear = 1'b0;
    tick();
    bus.byteReady = 1'b1;
    strobe(64'h0123456789ABCDEF, 1'b1);
    drain("t2", 64'h0123456789ABCDEF, 1'b1);
    chk("t2_idle_valid", 64'(bus.byteValid), 64'd0);
    chk("t2_idle_busy", 64'(bus.busy), 64'd0);
    strobe(64'h0123456789ABCDEF, 1'b0);
    got = 0;
    for (int k = 0; k < 40 && got < 8; k++) begin
      rdy = (k % 2) == 0;
      bus.byteReady = rdy;
      prev = bus.byteOut;
      if (bus.byteValid && rdy) begin
        chk("t3_byte", 64'(bus.byteOut), 64'(byte_of(64'h0123456789ABCDEF, got)));
        got++;
      end
      tick();
      if (!rdy) chk("t3_hold", 64'(bus.byteOut), 64'(prev));
    end
    chk("t3_count", 64'(got), 64'd8);
    chk("t3_idle", 64'(bus.byteValid), 64'd0);
    bus.byteReady = 1'b0;
    strobe(64'hAAAAAAAAAAAAAAAA, 1'b0);
    bus.check1 = 1'b1;
    strobe(64'hBBBBBBBBBBBBBBBB, 1'b1);
    bus.check1 = 1'b1;
    strobe(64'hCCCCCCCCCCCCCCCC, 1'b0);
    chk("t4_drop", 64'(bus.dropCount), 64'd1);
    chk("t4_busy", 64'(bus.busy), 64'd1);
    chk("t4_hold", 64'(bus.byteOut), 64'hAA);
    bus.byteReady = 1'b1;
    drain("t4a", 64'hAAAAAAAAAAAAAAAA, 1'b0);
    drain("t4b", 64'hBBBBBBBBBBBBBBBB, 1'b1);
    chk("t4_idle", 64'(bus.byteValid), 64'd0);
    strobe(64'h1111111111111111, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t5_byte", 64'(bus.byteOut), 64'h11);
      if (i == 7) begin
        bus.check1 = 1'b1;
        bus.checkData = 64'h2222222222222222;
        bus.check2 = 1'b1;
      end
      tick();
    end
    bus.check1 = 1'b0;
    drain("t5", 64'h2222222222222222, 1'b1);
    chk("t5_drop", 64'(bus.dropCount), 64'd1);
    chk("t5_idle", 64'(bus.busy), 64'd0);
    bus.byteReady = 1'b0;
    strobe(64'h3333333333333333, 1'b1);
    strobe(64'h4444444444444444, 1'b1);
    bus.byteReady = 1'b1;
    repeat (3) tick();
    chk("t6_mid", 64'(bus.byteOut), 64'h33);
    bus.byteReady = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_valid", 64'(bus.byteValid), 64'd0);
    chk("t6_last", 64'(bus.byteLast), 64'd0);
    chk("t6_tag", 64'(bus.tagOut), 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_byte", 64'(bus.byteOut), 64'd0);
    chk("t6_drop", 64'(bus.dropCount), 64'd0);
    bus.byteReady = 1'b1;
    strobe(64'h00000000000000FF, 1'b0);
    drain("t6", 64'h00000000000000FF, 1'b0);
    chk("t6_idle", 64'(bus.busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
